// File: rtl/udp_rx_pkg.sv
// Shared constants for the UDP receive dispatcher.
// Optional IPv4 header checksum check is enabled with UDP_RX_IP_CSUM_EN.
package udp_rx_pkg;

  // Parser states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ETH      = 3'd1;
  localparam logic [2:0] ST_IP_HDR   = 3'd2;
  localparam logic [2:0] ST_UDP_HDR  = 3'd3;
  localparam logic [2:0] ST_PAYLOAD  = 3'd4;
  localparam logic [2:0] ST_DISCARD  = 3'd5;

  localparam logic [15:0] ETH_IPV4      = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/ip_csum16.sv
// One step of the IPv4 header one's-complement sum: adds both 16-bit halves
// of a header word into the running sum with end-around carry.
// Only built when UDP_RX_IP_CSUM_EN is defined.
`ifdef UDP_RX_IP_CSUM_EN
module ip_csum16 (
  input  logic [15:0] i_acc,
  input  logic [31:0] i_word,
  output logic [15:0] o_sum
);

  logic [16:0] w_s1;
  logic [15:0] w_f1;
  logic [16:0] w_s2;

  // Two 17-bit adds, each folding its carry back into bit 0
  always_comb begin
    w_s1  = {1'b0, i_acc} + {1'b0, i_word[31:16]};
    w_f1  = w_s1[15:0] + {15'd0, w_s1[16]};
    w_s2  = {1'b0, w_f1} + {1'b0, i_word[15:0]};
    o_sum = w_s2[15:0] + {15'd0, w_s2[16]};
  end

endmodule
`endif

// File: rtl/udp_port_match.sv
// Compares a UDP destination port against N_CH channel ports.
// A channel port of 0 is disabled; the lowest matching index wins.
module udp_port_match #(
  parameter int unsigned N_CH = 4
) (
  input  logic [16*N_CH-1:0] i_ch_port,
  input  logic [15:0]        i_dport,
  output logic               o_hit,
  output logic [2:0]         o_idx
);

  // Scan from the top down so the lowest matching index is the one kept
  always_comb begin
    o_hit = 1'b0;
    o_idx = 3'd0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if ((i_ch_port[16*k +: 16] != 16'd0) && (i_ch_port[16*k +: 16] == i_dport)) begin
        o_hit = 1'b1;
        o_idx = 3'(k);
      end
    end
  end

endmodule

// File: rtl/udp_rx_dispatch.sv
// Ethernet/IPv4/UDP receive parser: filters by MAC and IP, matches the UDP
// destination port to a channel and streams the payload to that channel.
// Define UDP_RX_IP_CSUM_EN to also verify the IPv4 header checksum.
module udp_rx_dispatch
  import udp_rx_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter bit          ALLOW_BCAST = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [47:0]         i_self_mac,
  input  logic [31:0]         i_self_ip,
  input  logic [16*N_CH-1:0]  i_ch_port,
  input  logic [31:0]         i_in_data,
  input  logic                i_in_sop,
  input  logic                i_in_eop,
  input  logic                i_in_vld,
  output logic                o_in_rdy,
  output logic [31:0]         o_ch_data,
  output logic [N_CH-1:0]     o_ch_vld,
  output logic                o_ch_sop,
  output logic                o_ch_eop,
  output logic [1:0]          o_ch_empty,
  output logic                o_ch_err,
  input  logic [N_CH-1:0]     i_ch_rdy,
  output logic [CNT_W-1:0]    o_ok_cnt,
  output logic [CNT_W-1:0]    o_drop_cnt
);

  logic [2:0]       r_state, w_state_d;
  logic [3:0]       r_cnt, w_cnt_d;
  logic [3:0]       r_ihl, w_ihl_d;
  logic [15:0]      r_mac_hi, w_mac_hi_d;
  logic [2:0]       r_sel, w_sel_d;
  logic [15:0]      r_rem, w_rem_d;
  logic             r_first, w_first_d;
  logic [CNT_W-1:0] r_ok_cnt, r_drop_cnt;

  logic             w_xfer;
  logic             w_in_pay;
  logic             w_last;
  logic             w_sel_rdy;
  logic             w_hit;
  logic [2:0]       w_idx;
  logic             w_fail;
  logic             w_len8;
  logic             w_ip_last;
  logic             w_mac_self;
  logic             w_mac_bcast;
  logic             w_csum_bad;
  logic             w_ok_inc;
  logic [1:0]       w_drop_inc;
  logic [2:0]       w_empty_raw;
  logic [CNT_W:0]   w_ok_sum, w_drop_sum;

  assign w_xfer      = i_in_vld && o_in_rdy;
  assign w_in_pay    = (r_state == ST_PAYLOAD);
  assign w_last      = (r_rem <= 16'd4);
  assign w_ip_last   = (r_cnt != 4'd0) && (r_cnt == r_ihl - 4'd1);
  assign w_mac_self  = ({r_mac_hi, i_in_data} == i_self_mac);
  assign w_mac_bcast = ALLOW_BCAST && ({r_mac_hi, i_in_data} == BCAST_MAC);
  assign w_empty_raw = 3'd4 - r_rem[2:0];

  udp_port_match #(
    .N_CH (N_CH)
  ) u_port_match (
    .i_ch_port (i_ch_port),
    .i_dport   (i_in_data[15:0]),
    .o_hit     (w_hit),
    .o_idx     (w_idx)
  );

`ifdef UDP_RX_IP_CSUM_EN
  logic [15:0] r_csum;
  logic [15:0] w_csum_acc;
  logic [15:0] w_csum_sum;

  // The sum restarts at IP header word 0
  assign w_csum_acc = (r_cnt == 4'd0) ? 16'd0 : r_csum;
  assign w_csum_bad = (w_csum_sum != 16'hFFFF);

  ip_csum16 u_csum (
    .i_acc  (w_csum_acc),
    .i_word (i_in_data),
    .o_sum  (w_csum_sum)
  );

  // Running header sum, updated on every IP header transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= 16'd0;
    end else if (w_xfer && (r_state == ST_IP_HDR)) begin
      r_csum <= w_csum_sum;
    end
  end
`else
  assign w_csum_bad = 1'b0;
`endif

  // Header field checks for the word currently presented
  always_comb begin
    w_fail = 1'b0;
    w_len8 = 1'b0;
    case (r_state)
      ST_ETH: begin
        if (r_cnt == 4'd0) begin
          w_fail = !(w_mac_self || w_mac_bcast);
        end else if (r_cnt == 4'd2) begin
          w_fail = (i_in_data[15:0] != ETH_IPV4);
        end
      end
      ST_IP_HDR: begin
        case (r_cnt)
          4'd0: w_fail = (i_in_data[31:28] != 4'd4) || (i_in_data[27:24] < 4'd5);
          4'd1: w_fail = i_in_data[13] || (i_in_data[12:0] != 13'd0);
          4'd2: w_fail = (i_in_data[23:16] != IP_PROTO_UDP);
          4'd4: w_fail = (i_in_data != i_self_ip);
          default: ;
        endcase
        if (w_ip_last && w_csum_bad) begin
          w_fail = 1'b1;
        end
      end
      ST_UDP_HDR: begin
        if (r_cnt == 4'd0) begin
          w_fail = !w_hit;
        end else begin
          w_fail = (i_in_data[31:16] < UDP_HDR_BYTES);
          w_len8 = (i_in_data[31:16] == UDP_HDR_BYTES);
        end
      end
      default: ;
    endcase
  end

  // Next-state and counter-increment decisions for each transfer
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_ihl_d    = r_ihl;
    w_mac_hi_d = r_mac_hi;
    w_sel_d    = r_sel;
    w_rem_d    = r_rem;
    w_first_d  = r_first;
    w_ok_inc   = 1'b0;
    w_drop_inc = 2'd0;
    if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_sop && i_in_eop) begin
            w_drop_inc = 2'd1;
          end else if (i_in_sop) begin
            w_mac_hi_d = i_in_data[15:0];
            w_cnt_d    = 4'd0;
            w_state_d  = ST_ETH;
          end
        end
        ST_ETH, ST_IP_HDR, ST_UDP_HDR, ST_DISCARD: begin
          if (i_in_sop) begin
            // Current frame is lost; the sop word restarts parsing as w0.
            // A one-word new frame is itself a drop as well.
            if (i_in_eop) begin
              w_drop_inc = 2'd2;
              w_state_d  = ST_IDLE;
            end else begin
              w_drop_inc = 2'd1;
              w_mac_hi_d = i_in_data[15:0];
              w_cnt_d    = 4'd0;
              w_state_d  = ST_ETH;
            end
          end else if (r_state == ST_DISCARD) begin
            if (i_in_eop) begin
              w_state_d = ST_IDLE;
            end
          end else if (w_fail) begin
            w_drop_inc = 2'd1;
            w_state_d  = i_in_eop ? ST_IDLE : ST_DISCARD;
          end else if (w_len8) begin
            w_ok_inc  = 1'b1;
            w_state_d = i_in_eop ? ST_IDLE : ST_DISCARD;
          end else if (i_in_eop) begin
            w_drop_inc = 2'd1;
            w_state_d  = ST_IDLE;
          end else begin
            case (r_state)
              ST_ETH: begin
                if (r_cnt == 4'd2) begin
                  w_cnt_d   = 4'd0;
                  w_state_d = ST_IP_HDR;
                end else begin
                  w_cnt_d = r_cnt + 4'd1;
                end
              end
              ST_IP_HDR: begin
                if (r_cnt == 4'd0) begin
                  w_ihl_d = i_in_data[27:24];
                end
                if (w_ip_last) begin
                  w_cnt_d   = 4'd0;
                  w_state_d = ST_UDP_HDR;
                end else begin
                  w_cnt_d = r_cnt + 4'd1;
                end
              end
              default: begin
                if (r_cnt == 4'd0) begin
                  w_sel_d = w_idx;
                  w_cnt_d = 4'd1;
                end else begin
                  w_rem_d   = i_in_data[31:16] - UDP_HDR_BYTES;
                  w_first_d = 1'b1;
                  w_state_d = ST_PAYLOAD;
                end
              end
            endcase
          end
        end
        ST_PAYLOAD: begin
          w_first_d = 1'b0;
          w_rem_d   = r_rem - 16'd4;
          if (i_in_sop) begin
            // Abort: the new frame is counted and discarded
            w_drop_inc = 2'd1;
            w_state_d  = i_in_eop ? ST_IDLE : ST_DISCARD;
          end else if (w_last) begin
            w_ok_inc  = 1'b1;
            w_state_d = i_in_eop ? ST_IDLE : ST_DISCARD;
          end else if (i_in_eop) begin
            w_drop_inc = 2'd1;
            w_state_d  = ST_IDLE;
          end
        end
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  assign w_ok_sum   = {1'b0, r_ok_cnt} + {{CNT_W{1'b0}}, w_ok_inc};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W - 1){1'b0}}, w_drop_inc};

  // Parser state and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_ihl      <= 4'd0;
      r_mac_hi   <= 16'd0;
      r_sel      <= 3'd0;
      r_rem      <= 16'd0;
      r_first    <= 1'b0;
      r_ok_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_ihl      <= w_ihl_d;
      r_mac_hi   <= w_mac_hi_d;
      r_sel      <= w_sel_d;
      r_rem      <= w_rem_d;
      r_first    <= w_first_d;
      r_ok_cnt   <= w_ok_sum[CNT_W] ? '1 : w_ok_sum[CNT_W-1:0];
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

  // Combinational payload passthrough to the selected channel
  always_comb begin
    w_sel_rdy = 1'b0;
    o_ch_vld  = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (r_sel == 3'(k)) begin
        w_sel_rdy   = i_ch_rdy[k];
        o_ch_vld[k] = w_in_pay && i_in_vld;
      end
    end
    o_in_rdy   = !rst_n ? 1'b0 : (w_in_pay ? w_sel_rdy : 1'b1);
    o_ch_data  = i_in_data;
    o_ch_sop   = w_in_pay && r_first;
    o_ch_eop   = w_in_pay && (w_last || i_in_eop || i_in_sop);
    o_ch_err   = w_in_pay && (i_in_sop || (i_in_eop && !w_last));
    o_ch_empty = (w_in_pay && w_last && !i_in_sop) ? w_empty_raw[1:0] : 2'd0;
  end

  assign o_ok_cnt   = r_ok_cnt;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_dispatch.sv
// Table-driven bench for udp_rx_dispatch: frames are expanded into
// per-word vectors with hand-derived expected channel outputs and counters.
module tb_udp_rx_dispatch;

  localparam int N = 4;
`ifdef UDP_RX_IP_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  localparam logic [47:0] SELF_MAC = 48'h0200_00AB_CDEF;
  localparam logic [31:0] SELF_IP  = 32'hC0A8_0164;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [47:0]       i_self_mac;
  logic [31:0]       i_self_ip;
  logic [16*N-1:0]   i_ch_port;
  logic [31:0]       i_in_data;
  logic              i_in_sop, i_in_eop, i_in_vld;
  logic              o_in_rdy;
  logic [31:0]       o_ch_data;
  logic [N-1:0]      o_ch_vld;
  logic              o_ch_sop, o_ch_eop, o_ch_err;
  logic [1:0]        o_ch_empty;
  logic [N-1:0]      i_ch_rdy;
  logic [15:0]       o_ok_cnt, o_drop_cnt;

  udp_rx_dispatch #(
    .N_CH        (N),
    .ALLOW_BCAST (1'b1),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_self_mac (i_self_mac),
    .i_self_ip  (i_self_ip),
    .i_ch_port  (i_ch_port),
    .i_in_data  (i_in_data),
    .i_in_sop   (i_in_sop),
    .i_in_eop   (i_in_eop),
    .i_in_vld   (i_in_vld),
    .o_in_rdy   (o_in_rdy),
    .o_ch_data  (o_ch_data),
    .o_ch_vld   (o_ch_vld),
    .o_ch_sop   (o_ch_sop),
    .o_ch_eop   (o_ch_eop),
    .o_ch_empty (o_ch_empty),
    .o_ch_err   (o_ch_err),
    .i_ch_rdy   (i_ch_rdy),
    .o_ok_cnt   (o_ok_cnt),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop, eop, vld;
    logic [3:0]  rdy;
    logic        ex_rdy;
    logic [3:0]  ex_vld;
    logic        ex_sop, ex_eop;
    logic [1:0]  ex_empty;
    logic        ex_err;
    logic        chk_cnt;
    int          ex_ok, ex_drop;
  } vec_t;

  vec_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cur   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, cur, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] d, input logic s, input logic e, input logic [3:0] r,
                     input logic xr, input logic [3:0] xv, input logic xs, input logic xe,
                     input logic [1:0] xm, input logic xerr);
    vec_t v;
    v.data = d; v.sop = s; v.eop = e; v.vld = 1'b1; v.rdy = r;
    v.ex_rdy = xr; v.ex_vld = xv; v.ex_sop = xs; v.ex_eop = xe;
    v.ex_empty = xm; v.ex_err = xerr; v.chk_cnt = 1'b0; v.ex_ok = 0; v.ex_drop = 0;
    q.push_back(v);
  endtask

  // Header / filler word: consumed with no channel output
  task automatic quiet(input logic [31:0] d, input logic s, input logic e);
    add(d, s, e, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic cnt_chk(input int ok, input int drop);
    vec_t v;
    v.data = 32'h0; v.sop = 1'b0; v.eop = 1'b0; v.vld = 1'b0; v.rdy = 4'hF;
    v.ex_rdy = 1'b1; v.ex_vld = 4'h0; v.ex_sop = 1'b0; v.ex_eop = 1'b0;
    v.ex_empty = 2'd0; v.ex_err = 1'b0; v.chk_cnt = 1'b1; v.ex_ok = ok; v.ex_drop = drop;
    q.push_back(v);
  endtask

  // Ethernet + IPv4 + UDP header words (with a valid header checksum unless csum_x != 0)
  task automatic hdr(input logic [47:0] mac, input logic [15:0] etype, input int ihl,
                     input logic mf, input logic [7:0] proto, input logic [15:0] dport,
                     input logic [15:0] ulen, input logic [15:0] csum_x);
    logic [31:0] ip [16];
    logic [31:0] sum;
    ip[0] = {4'h4, 4'(ihl), 8'h00, 16'(ihl * 4) + ulen};
    ip[1] = {16'h1234, 2'b00, mf, 13'h0};
    ip[2] = {8'd64, proto, 16'h0};
    ip[3] = 32'h0A00_0001;
    ip[4] = SELF_IP;
    for (int i = 5; i < 16; i++) ip[i] = 32'h0101_0101;
    sum = 32'h0;
    for (int i = 0; i < ihl; i++) sum = sum + {16'h0, ip[i][31:16]} + {16'h0, ip[i][15:0]};
    while (sum > 32'h0000_FFFF) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    ip[2][15:0] = ~sum[15:0] ^ csum_x;
    quiet({16'h0, mac[47:32]}, 1'b1, 1'b0);
    quiet(mac[31:0], 1'b0, 1'b0);
    quiet(32'h0011_2233, 1'b0, 1'b0);
    quiet({16'h4455, etype}, 1'b0, 1'b0);
    for (int i = 0; i < ihl; i++) quiet(ip[i], 1'b0, 1'b0);
    quiet({16'd5555, dport}, 1'b0, 1'b0);
    quiet({ulen, 16'h0}, 1'b0, 1'b0);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    i_in_data = v.data; i_in_sop = v.sop; i_in_eop = v.eop; i_in_vld = v.vld;
    i_ch_rdy  = v.rdy;
    #2;
    chk("in_rdy", 32'(o_in_rdy), 32'(v.ex_rdy));
    chk("ch_vld", 32'(o_ch_vld), 32'(v.ex_vld));
    if (v.ex_vld != 4'h0) begin
      chk("ch_data", o_ch_data, v.data);
      chk("ch_sop", 32'(o_ch_sop), 32'(v.ex_sop));
      chk("ch_eop", 32'(o_ch_eop), 32'(v.ex_eop));
      chk("ch_empty", 32'(o_ch_empty), 32'(v.ex_empty));
      chk("ch_err", 32'(o_ch_err), 32'(v.ex_err));
    end
    if (v.chk_cnt) begin
      chk("ok_cnt", 32'(o_ok_cnt), v.ex_ok);
      chk("drop_cnt", 32'(o_drop_cnt), v.ex_drop);
    end
    cur++;
  endtask

  task automatic run_q();
    foreach (q[i]) apply(q[i]);
    q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    i_self_mac = SELF_MAC;
    i_self_ip  = SELF_IP;
    i_ch_port  = {16'd3000, 16'd0, 16'd2000, 16'd1000};
    i_in_data  = 32'h0; i_in_sop = 1'b0; i_in_eop = 1'b0; i_in_vld = 1'b0;
    i_ch_rdy   = 4'hF;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_rdy", 32'(o_in_rdy), 32'h0);
    chk("rst_vld", 32'(o_ch_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_chk(0, 0);

    // Unicast, ch1, len 20: three payload words
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd2000, 16'd20, 16'h0);
    add(32'hA1A2A3A4, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    add(32'hB1B2B3B4, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    add(32'hC1C2C3C4, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd0, 1'b0);
    cnt_chk(1, 0);
    // len 13 on ch0: two words, empty 3, then two pad words
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd1000, 16'd13, 16'h0);
    add(32'h1111_2222, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    add(32'h3300_0000, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd3, 1'b0);
    quiet(32'hEEEE_EEEE, 1'b0, 1'b0);
    quiet(32'hFFFF_FFFF, 1'b0, 1'b1);
    cnt_chk(2, 0);
    // IHL 7 with options, ch3, len 12: one word
    hdr(SELF_MAC, 16'h0800, 7, 1'b0, 8'd17, 16'd3000, 16'd12, 16'h0);
    add(32'h5A5A_A5A5, 1'b0, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd0, 1'b0);
    cnt_chk(3, 0);
    // Same frame with MF set: dropped
    hdr(SELF_MAC, 16'h0800, 7, 1'b1, 8'd17, 16'd3000, 16'd12, 16'h0);
    quiet(32'h5A5A_A5A5, 1'b0, 1'b1);
    cnt_chk(3, 1);
    // Five-cycle stall on ch1 mid-payload, len 24
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd2000, 16'd24, 16'h0);
    add(32'h0000_0001, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(32'h0000_0002, 1'b0, 1'b0, 4'b1101, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    add(32'h0000_0002, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    add(32'h0000_0003, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    add(32'h0000_0004, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd0, 1'b0);
    cnt_chk(4, 1);
    // Truncated at rem=8, then a good frame
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd2000, 16'd20, 16'h0);
    add(32'hDEAD_0001, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    add(32'hDEAD_0002, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd0, 1'b1);
    cnt_chk(4, 2);
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd2000, 16'd12, 16'h0);
    add(32'h600D_600D, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd0, 1'b0);
    cnt_chk(5, 2);
    // Filter rejects: wrong MAC, ARP, unmatched port, disabled port 0
    hdr(48'h0200_00AB_CDEE, 16'h0800, 5, 1'b0, 8'd17, 16'd2000, 16'd12, 16'h0);
    quiet(32'h1, 1'b0, 1'b1);
    hdr(SELF_MAC, 16'h0806, 5, 1'b0, 8'd17, 16'd2000, 16'd12, 16'h0);
    quiet(32'h2, 1'b0, 1'b1);
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd4000, 16'd12, 16'h0);
    quiet(32'h3, 1'b0, 1'b1);
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd0, 16'd12, 16'h0);
    quiet(32'h4, 1'b0, 1'b1);
`ifdef UDP_RX_IP_CSUM_EN
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd2000, 16'd12, 16'h0100);
    quiet(32'h5, 1'b0, 1'b1);
`endif
    cnt_chk(5, 6 + CS);
    // len 8 counts ok with no output; len 5 is dropped
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd1000, 16'd8, 16'h0);
    quiet(32'h6, 1'b0, 1'b1);
    cnt_chk(6, 6 + CS);
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd1000, 16'd5, 16'h0);
    quiet(32'h7, 1'b0, 1'b1);
    cnt_chk(6, 7 + CS);
    // Abort by sop mid-payload, then broadcast frame with len 9
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd1000, 16'd20, 16'h0);
    add(32'hAB00_0001, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    add(32'h0000_0200, 1'b1, 1'b0, 4'hF, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1);
    quiet(32'h8, 1'b0, 1'b1);
    cnt_chk(6, 8 + CS);
    hdr(48'hFFFF_FFFF_FFFF, 16'h0800, 5, 1'b0, 8'd17, 16'd3000, 16'd9, 16'h0);
    add(32'h7700_0000, 1'b0, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
    cnt_chk(7, 8 + CS);
    run_q();

    // Reset in the middle of a payload
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd2000, 16'd20, 16'h0);
    add(32'h1234_5678, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    run_q();
    @(negedge clk);
    rst_n    = 1'b0;
    i_in_vld = 1'b1;
    #2;
    chk("midrst_rdy", 32'(o_in_rdy), 32'h0);
    chk("midrst_vld", 32'(o_ch_vld), 32'h0);
    chk("midrst_eop", 32'(o_ch_eop), 32'h0);
    chk("midrst_ok", 32'(o_ok_cnt), 32'h0);
    chk("midrst_drop", 32'(o_drop_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(32'h9ABC_DEF0, 1'b0, 1'b0);
    quiet(32'h9ABC_DEF1, 1'b0, 1'b1);
    hdr(SELF_MAC, 16'h0800, 5, 1'b0, 8'd17, 16'd1000, 16'd12, 16'h0);
    add(32'h0BAD_F00D, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
    cnt_chk(1, 0);
    run_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_dispatch.md
Name: udp_rx_dispatch

Overview:
- Next-generation receive parser for the 32-bit Ethernet RX stream.
- Filters frames by destination MAC and IP, and parses Ethernet/IPv4/UDP headers, including variable IHL and options.
- Matches the UDP destination port against N_CH programmable ports and streams the UDP payload, with byte-accurate end and backpressure, to the matching channel.
- Sits between the MAC RX FIFO and per-function payload consumers (register access, waveform/VRC load, bulk data).

Parameters:
- N_CH, 4, number of payload channels (1..8).
- ALLOW_BCAST, 1, accept destination MAC FF:FF:FF:FF:FF:FF in addition to i_self_mac.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_self_mac  in  48  own MAC address
- i_self_ip  in  32  own IPv4 address
- i_ch_port  in  16*N_CH  UDP destination port per channel, ch k at [16k+15:16k]; value 0 disables the channel
- i_in_data  in  32  input word, big-endian byte order
- i_in_sop  in  1  first word of frame
- i_in_eop  in  1  last word of frame
- i_in_vld  in  1  input word valid
- o_in_rdy  out  1  input ready
- o_ch_data  out  32  payload word, shared by all channels; equals i_in_data
- o_ch_vld  out  N_CH  one-hot payload valid
- o_ch_sop  out  1  first payload word
- o_ch_eop  out  1  last payload word
- o_ch_empty  out  2  invalid low-order bytes in the eop word
- o_ch_err  out  1  qualifies eop: frame truncated or aborted
- i_ch_rdy  in  N_CH  per-channel ready
- o_ok_cnt  out  CNT_W  accepted datagrams
- o_drop_cnt  out  CNT_W  dropped frames

Behaviour:
- Frame layout:
  - w0 = {16'h0, dst_mac[47:32]}; w1 = dst_mac[31:0]; w2 = src_mac[47:16]; w3 = {src_mac[15:0], ethertype}.
  - w4.. = IPv4 header of IHL words, then 2 UDP header words, then payload, then padding/FCS words up to eop.
- States: IDLE, ETH, IP_HDR, UDP_HDR, PAYLOAD, DISCARD. A word is transferred when i_in_vld && o_in_rdy.
- IDLE: a transfer with sop latches w0 and goes to ETH. Words without sop are ignored.
- ETH (w1..w3):
  - At w1, the MAC must equal i_self_mac, or be all-ones when ALLOW_BCAST=1; otherwise go to DISCARD.
  - At w3, ethertype must be 16'h0800; otherwise go to DISCARD.
- IP_HDR:
  - Word 0 requires version 4 and IHL >= 5; latch IHL.
  - Word 1 requires MF=0 and fragment offset=0 (no fragments).
  - Word 2 latches the protocol, which must be 17.
  - Word 4 (dst IP) must equal i_self_ip.
  - Options words (IHL-5) are consumed unchecked. Go to UDP_HDR after IHL words; any failure goes to DISCARD.
- UDP_HDR:
  - Word 0 matches the dst port against all enabled channels; the lowest index wins; no match goes to DISCARD.
  - Word 1 latches len. len < 8 goes to DISCARD. len == 8 counts as OK and goes to DISCARD (no output).
  - Otherwise rem = len-8 and the state becomes PAYLOAD.
- PAYLOAD, for selected channel s:
  - o_ch_vld[s] = i_in_vld; o_in_rdy = i_ch_rdy[s]; zero latency, combinational passthrough.
  - o_ch_sop on the first word. Per transfer, rem -= 4.
  - When rem <= 4: o_ch_eop=1, o_ch_empty = (4-rem)[1:0], o_ok_cnt++. Then go to IDLE if i_in_eop, else DISCARD.
- Outside PAYLOAD, o_in_rdy=1 and o_ch_vld=0.
- DISCARD: consume words until an eop transfer, then go to IDLE.
- Any eop transfer before the header is complete (ETH, IP_HDR, UDP_HDR): o_drop_cnt++, go to IDLE.
- Truncation: i_in_eop in PAYLOAD while rem > 4: word forwarded with o_ch_eop=1, o_ch_err=1, o_ch_empty=0; o_drop_cnt++.
- Abort: i_in_sop in PAYLOAD: word forwarded with o_ch_eop=1, o_ch_err=1. The new frame is dropped (o_drop_cnt++) and the state becomes DISCARD, or IDLE if eop.
- Mid-frame sop in ETH, IP_HDR, UDP_HDR or DISCARD: the current frame counts as a drop and parsing restarts at w0.
- Each DISCARD entry caused by a failed check increments o_drop_cnt once.
- Counters saturate at all-ones.
- i_self_mac, i_self_ip and i_ch_port are sampled at their check words only; they are quasi-static.
- Reset (including mid-frame): state IDLE; o_ch_vld=0, o_ch_sop/eop/err=0, o_ch_empty=0, counters 0; o_in_rdy=0 while rst_n=0. After reset, input words before the next sop are ignored.

Optional Feature:
- Macro: UDP_RX_IP_CSUM_EN.
- Defined:
  - One's-complement sum over all IHL header words is accumulated in IP_HDR (17-bit add with end-around carry per 16-bit half).
  - At the last header word, a result != 16'hFFFF goes to DISCARD with o_drop_cnt++.
- Undefined: the checksum is ignored and no adder is built.

Decomposition:
- Package udp_rx_pkg: state enum; constants ETH_IPV4=16'h0800, IP_PROTO_UDP=8'd17, UDP_HDR_BYTES=8, BCAST_MAC.
- Sub-module udp_port_match: combinational N_CH comparator with priority encoder, producing hit and index.
- Optional sub-module ip_csum16 under UDP_RX_IP_CSUM_EN.

Test Plan:
- Unicast to self, port = i_ch_port[1], UDP len=20 -> 3 words on ch1; sop on word1; eop on word3 with empty=0; o_ok_cnt=1.
- UDP len=13 followed by 2 pad words and eop -> 2 payload words, empty=3; pads consumed with o_ch_vld=0.
- IHL=7 (2 option words), len=12 -> options skipped; 1 word on the correct channel. Same frame with MF=1 -> no output, o_drop_cnt=1.
- i_ch_rdy[s] held low for 5 cycles mid-payload -> o_in_rdy=0 during the stall; no word lost or duplicated; data order preserved.
- Frame ends with eop when rem=8 -> eop with err=1; o_drop_cnt++; the next good frame is delivered normally.
- Wrong dst MAC, ARP ethertype 0806, unmatched port, and (with the macro) corrupted checksum -> no o_ch_vld; o_drop_cnt increments by 4.
